// File: rtl/ibex_fetch_align_queue.sv
// ibex_fetch_align_queue
//
// Buffers word-aligned instruction-fetch responses. Each handshake presents
// one aligned instruction to the IF-ID register. It handles 16-bit compressed
// and 32-bit instructions, including 32-bit instructions that straddle two
// fetch words. Each instruction carries its PC and fetch-error flags.
// clear_i (controller pc_set) flushes the queue and redirects the PC.
//
// Optional build macro: IBEX_FETCH_QUEUE_OCC_EN
//   When defined, adds the occ_o port (the registered entry count) and an
//   assertion that a push never targets a full queue.

module ibex_fetch_align_queue #(
    parameter int unsigned Depth = 3  // 32-bit word entries, legal range 2..8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic [31:0] clear_addr_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic        out_is_compressed_o,
    output logic [31:0] out_addr_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o,
    output logic        busy_o
`ifdef IBEX_FETCH_QUEUE_OCC_EN
    ,
    output logic [$clog2(Depth+1)-1:0] occ_o
`endif
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

    // Advance a circular pointer; Depth need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == LastPtr) begin
            return '0;
        end else begin
            return p + PtrW'(1);
        end
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]     mem_data_q [Depth];
    logic            mem_err_q  [Depth];

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q,  count_d;
    logic            offset_q, offset_d;  // 1: instruction starts at the upper halfword
    logic [31:0]     pc_q,     pc_d;

    // Bit 0 of the redirect address is meaningless for halfword-aligned PCs.
    logic unused_clear_addr_bit0;
    assign unused_clear_addr_bit0 = clear_addr_i[0];

    // ------------------------------------------------------------------
    // Head / next entry views
    // ------------------------------------------------------------------
    logic [PtrW-1:0] nx_ptr;
    logic [31:0]     head_data, next_data;
    logic            head_err,  next_err;

    assign nx_ptr    = ptr_inc(rd_ptr_q);
    assign head_data = mem_data_q[rd_ptr_q];
    assign head_err  = mem_err_q[rd_ptr_q];
    assign next_data = mem_data_q[nx_ptr];
    assign next_err  = mem_err_q[nx_ptr];

    logic has_one;
    logic has_two;

    assign has_one = (count_q != '0);
    assign has_two = (count_q >= CntW'(2));

    // ------------------------------------------------------------------
    // Instruction alignment
    // ------------------------------------------------------------------
    logic        instr_valid;
    logic [31:0] instr_data;
    logic        instr_is_c;
    logic        instr_err;
    logic        instr_plus2;
    logic        instr_pops_word;  // accepting this instruction retires the head word

    // Build the aligned instruction from the head (and next) entry.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the if/else tree leaves a value held, which would
        // infer a latch.
        instr_valid     = 1'b0;
        instr_data      = '0;
        instr_is_c      = 1'b0;
        instr_err       = 1'b0;
        instr_plus2     = 1'b0;
        instr_pops_word = 1'b0;

        if (!offset_q) begin
            // Instruction starts at the lower halfword of the head word.
            instr_is_c      = (head_data[1:0] != 2'b11);
            instr_valid     = has_one;
            instr_data      = instr_is_c ? {16'h0, head_data[15:0]} : head_data;
            instr_err       = head_err;
            instr_pops_word = !instr_is_c;
        end else if (head_data[17:16] != 2'b11) begin
            // Compressed instruction in the upper halfword.
            instr_is_c      = 1'b1;
            instr_valid     = has_one;
            instr_data      = {16'h0, head_data[31:16]};
            instr_err       = head_err;
            instr_pops_word = 1'b1;
        end else begin
            // 32-bit instruction that straddles the head and next words.
            instr_is_c      = 1'b0;
            instr_data      = {next_data[15:0], head_data[31:16]};
            instr_pops_word = 1'b1;
            if (head_err && has_one) begin
                // The first half already faulted; do not wait for the second word.
                instr_valid = 1'b1;
                instr_err   = 1'b1;
            end else begin
                instr_valid = has_two;
                if (next_err) begin
                    instr_err   = 1'b1;
                    instr_plus2 = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic push;
    logic pop;
    logic pop_word;

    assign in_ready_o = (count_q < DepthCnt);
    assign push       = in_valid_i & in_ready_o & ~clear_i;
    assign pop        = instr_valid & out_ready_i & ~clear_i;
    assign pop_word   = pop & instr_pops_word;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Compute pointer, count, offset and PC updates; clear_i has priority.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        offset_d = offset_q;
        pc_d     = pc_q;

        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            offset_d = clear_addr_i[1];
            pc_d     = {clear_addr_i[31:1], 1'b0};
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                // A compressed instruction moves to the other halfword;
                // a 32-bit one keeps the same halfword alignment.
                offset_d = offset_q ^ instr_is_c;
                pc_d     = pc_q + (instr_is_c ? 32'd2 : 32'd4);
            end
            if (pop_word) begin
                rd_ptr_d = nx_ptr;
            end
            count_d = count_q + CntW'(push) - CntW'(pop_word);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Control state with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            offset_q <= 1'b0;
            pc_q     <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            offset_q <= offset_d;
            pc_q     <= pc_d;
        end
    end

    // Entry storage; written only on an accepted push.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array has no reset; count_q == 0 marks every entry
        // invalid, so stale contents are never presented.
        if (push) begin
            mem_data_q[wr_ptr_q] <= in_rdata_i;
            mem_err_q[wr_ptr_q]  <= in_err_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid_o         = instr_valid;
    assign out_rdata_o         = instr_valid ? instr_data : '0;
    assign out_is_compressed_o = instr_valid & instr_is_c;
    assign out_err_o           = instr_valid & instr_err;
    assign out_err_plus2_o     = instr_valid & instr_plus2;
    assign out_addr_o          = pc_q;
    assign busy_o              = (count_q != '0);

`ifdef IBEX_FETCH_QUEUE_OCC_EN
    assign occ_o = count_q;

    // A push must never land on a full queue.
    push_not_full_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && (count_q == DepthCnt)));
`endif

endmodule
